// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with guard gaps, frame-synchronous
// display update and leading-zero / invalid-code blanking.
module seg_scan_ctrl #(
    parameter int unsigned DIV   = 50000,
    parameter int unsigned GUARD = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld,
    input  logic [15:0] bcd_in,
    input  logic        lz_en,
    output logic [3:0]  an,
    output logic [3:0]  hex,
    output logic        pending,
    output logic        frame_tick
);

    localparam int unsigned CMAX = (DIV > GUARD) ? DIV : GUARD;
    localparam int unsigned CW   = $clog2(CMAX);

    localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD - 1);

    localparam logic [1:0] ST_GUARD = 2'd0;
    localparam logic [1:0] ST_SHOW  = 2'd1;

    logic [1:0]    state;
    logic [1:0]    idx;
    logic [CW-1:0] cnt;
    logic [15:0]   disp;
    logic [15:0]   shadow;
    logic          lz_q;
    logic          boundary;
    logic          lz_blank;
    logic          blank;
    logic          z1, z2, z3;

    assign boundary = (state == ST_SHOW) && (idx == 2'd3) && (cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_GUARD;
            idx     <= '0;
            cnt     <= '0;
            disp    <= '0;
            shadow  <= '0;
            pending <= 1'b0;
            lz_q    <= 1'b0;
        end else begin
            lz_q <= lz_en;

            case (state)
                ST_GUARD: begin
                    if (cnt == GUARD_LAST) begin
                        state <= ST_SHOW;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_SHOW: begin
                    if (cnt == DIV_LAST) begin
                        state <= ST_GUARD;
                        cnt   <= '0;
                        idx   <= idx + 2'd1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= ST_GUARD;
                    idx   <= '0;
                    cnt   <= '0;
                end
            endcase

            // A strobe landing on the boundary bypasses shadow so it is shown at once.
            if (boundary) begin
                if (ld) begin
                    disp   <= bcd_in;
                    shadow <= bcd_in;
                end else if (pending) begin
                    disp <= shadow;
                end
                pending <= 1'b0;
            end else if (ld) begin
                shadow  <= bcd_in;
                pending <= 1'b1;
            end
        end
    end

    assign hex = disp[{idx, 2'b00} +: 4];

    assign z3 = (disp[15:12] == 4'd0);
    assign z2 = z3 && (disp[11:8] == 4'd0);
    assign z1 = z2 && (disp[7:4] == 4'd0);

    always_comb begin
        lz_blank = 1'b0;
        case (idx)
            2'd1:    lz_blank = z1;
            2'd2:    lz_blank = z2;
            2'd3:    lz_blank = z3;
            default: lz_blank = 1'b0;
        endcase
    end

    assign blank      = (hex > 4'd9) || (lz_q && lz_blank);
    assign an         = ((state == ST_SHOW) && !blank) ? ~(4'b0001 << idx) : 4'b1111;
    assign frame_tick = boundary;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl (DIV=4, GUARD=2): a frame-position reference model
// queues expected outputs per cycle, plus directed scenario checks.
module tb_seg_scan_ctrl;

    localparam int G = 2;
    localparam int D = 4;
    localparam int P = G + D;
    localparam int F = 4 * P;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld;
    logic [15:0] bcd_in;
    logic        lz_en;
    logic [3:0]  an;
    logic [3:0]  hex;
    logic        pending;
    logic        frame_tick;

    seg_scan_ctrl #(.DIV(D), .GUARD(G)) dut (
        .clk        (clk),
        .reset      (reset),
        .ld         (ld),
        .bcd_in     (bcd_in),
        .lz_en      (lz_en),
        .an         (an),
        .hex        (hex),
        .pending    (pending),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] an;
        logic [3:0] hex;
        logic       pend;
        logic       tick;
    } exp_t;

    exp_t sbq[$];
    int   vectors = 0;
    int   errors  = 0;

    int          m_t;
    logic [15:0] m_disp;
    logic [15:0] m_shadow;
    logic        m_pend;
    logic        m_lz;
    logic        mvalid = 1'b0;

    logic [3:0] o_an, o_hex;
    logic       o_pend, o_tick;

    logic [3:0] scan_an [30] = '{
        4'hF, 4'hF, 4'hE, 4'hE, 4'hE, 4'hE,
        4'hF, 4'hF, 4'hD, 4'hD, 4'hD, 4'hD,
        4'hF, 4'hF, 4'hB, 4'hB, 4'hB, 4'hB,
        4'hF, 4'hF, 4'h7, 4'h7, 4'h7, 4'h7,
        4'hF, 4'hF, 4'hE, 4'hE, 4'hE, 4'hE
    };

    // Reference: outputs derived from position within the frame, not from a state machine.
    function automatic exp_t model_out();
        exp_t e;
        int digit, ph;
        logic [3:0] nib;
        logic blank;
        digit = m_t / P;
        ph    = m_t % P;
        nib   = m_disp[digit*4 +: 4];
        blank = (nib > 4'd9) || (m_lz && digit > 0 && (m_disp >> (digit*4)) == 16'd0);
        e.hex  = nib;
        e.an   = (ph >= G && !blank) ? ~(4'b0001 << digit) : 4'b1111;
        e.pend = m_pend;
        e.tick = (m_t == F - 1);
        return e;
    endfunction

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            vectors++;
            if (an !== e.an || hex !== e.hex || pending !== e.pend || frame_tick !== e.tick) begin
                errors++;
                $display("FAIL sb t=%0t got an=%b hex=%h pend=%b tick=%b exp an=%b hex=%h pend=%b tick=%b",
                         $time, an, hex, pending, frame_tick, e.an, e.hex, e.pend, e.tick);
            end
        end
    end

    task automatic cycle(input logic l, input logic [15:0] b, input logic z, input logic r);
        ld = l; bcd_in = b; lz_en = z; reset = r;
        if (mvalid) sbq.push_back(model_out());
        @(negedge clk);
        o_an = an; o_hex = hex; o_pend = pending; o_tick = frame_tick;
        @(posedge clk);
        if (r) begin
            m_t = 0; m_disp = '0; m_shadow = '0; m_pend = 1'b0; m_lz = 1'b0;
            mvalid = 1'b1;
        end else begin
            if (m_t == F - 1) begin
                if (l) begin
                    m_disp = b; m_shadow = b;
                end else if (m_pend) begin
                    m_disp = m_shadow;
                end
                m_pend = 1'b0;
            end else if (l) begin
                m_shadow = b; m_pend = 1'b1;
            end
            m_t  = (m_t + 1) % F;
            m_lz = z;
        end
        #1;
    endtask

    task automatic do_reset();
        cycle(1'b0, 16'h0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        cycle(1'b1, 16'hFFFF, 1'b0, 1'b1);
        cycle(1'b1, 16'hFFFF, 1'b0, 1'b1);
        cycle(1'b1, 16'hFFFF, 1'b0, 1'b1);
        vectors++;
        if (o_an !== 4'hF || o_hex !== 4'h0 || o_pend !== 1'b0 || o_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got an=%b hex=%h pend=%b tick=%b exp an=1111 hex=0 pend=0 tick=0",
                     o_an, o_hex, o_pend, o_tick);
        end
    endtask

    task automatic test_scan();
        int ticks = 0, tick_at = -1;
        for (int i = 0; i < 30; i++) begin
            cycle(1'b0, 16'h0, 1'b0, 1'b0);
            vectors++;
            if (o_an !== scan_an[i]) begin
                errors++;
                $display("FAIL scan_an cyc=%0d got %b exp %b", i, o_an, scan_an[i]);
            end
            if (o_tick === 1'b1) begin ticks++; tick_at = i; end
        end
        vectors++;
        if (ticks != 1 || tick_at != 23) begin
            errors++;
            $display("FAIL scan_tick got count=%0d at=%0d exp count=1 at=23", ticks, tick_at);
        end
    endtask

    task automatic test_load();
        logic [3:0] exp_hex [4] = '{4'h4, 4'h3, 4'h2, 4'h1};
        do_reset();
        for (int i = 0; i < 48; i++) begin
            cycle(i == 5, 16'h1234, 1'b0, 1'b0);
            if (i >= 6 && i <= 23) begin
                vectors++;
                if (o_pend !== 1'b1) begin
                    errors++;
                    $display("FAIL load_pend cyc=%0d got %b exp 1", i, o_pend);
                end
            end
            if (i == 24) begin
                vectors++;
                if (o_pend !== 1'b0) begin
                    errors++;
                    $display("FAIL load_pend_clr got %b exp 0", o_pend);
                end
            end
            if (i >= 26 && (i - 26) % P == 0) begin
                vectors++;
                if (o_hex !== exp_hex[(i - 26) / P]) begin
                    errors++;
                    $display("FAIL load_hex cyc=%0d got %h exp %h", i, o_hex, exp_hex[(i - 26) / P]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int ones = 0;
        do_reset();
        for (int i = 0; i < 48; i++) begin
            cycle(i == 3 || i == 10, (i == 3) ? 16'h1111 : 16'h5678, 1'b0, 1'b0);
            if (o_an !== 4'hF && o_hex === 4'h1) ones++;
            if (i == 26) begin
                vectors++;
                if (o_hex !== 4'h8) begin
                    errors++;
                    $display("FAIL b2b_hex0 got %h exp 8", o_hex);
                end
            end
            if (i == 44) begin
                vectors++;
                if (o_hex !== 4'h5) begin
                    errors++;
                    $display("FAIL b2b_hex3 got %h exp 5", o_hex);
                end
            end
        end
        vectors++;
        if (ones != 0) begin
            errors++;
            $display("FAIL b2b_stale got %0d shows of 1 exp 0", ones);
        end
    endtask

    task automatic test_boundary_ld();
        int nines = 0;
        do_reset();
        for (int i = 0; i < 48; i++) begin
            cycle(i == 4 || i == 23, (i == 4) ? 16'h9999 : 16'h0042, 1'b0, 1'b0);
            if (o_an !== 4'hF && o_hex === 4'h9) nines++;
            if (i == 23) begin
                vectors++;
                if (o_pend !== 1'b1 || o_tick !== 1'b1) begin
                    errors++;
                    $display("FAIL bnd_pre got pend=%b tick=%b exp pend=1 tick=1", o_pend, o_tick);
                end
            end
            if (i == 24) begin
                vectors++;
                if (o_pend !== 1'b0) begin
                    errors++;
                    $display("FAIL bnd_pend got %b exp 0", o_pend);
                end
            end
            if (i == 26 || i == 32) begin
                vectors++;
                if (o_hex !== ((i == 26) ? 4'h2 : 4'h4)) begin
                    errors++;
                    $display("FAIL bnd_hex cyc=%0d got %h exp %h", i, o_hex, (i == 26) ? 4'h2 : 4'h4);
                end
            end
        end
        vectors++;
        if (nines != 0) begin
            errors++;
            $display("FAIL bnd_stale got %0d shows of 9 exp 0", nines);
        end
    endtask

    task automatic test_lz();
        logic [3:0] exp_an [16] = '{
            4'hE, 4'hD, 4'hF, 4'hF,
            4'hE, 4'hD, 4'hB, 4'h7,
            4'hE, 4'hF, 4'hB, 4'h7,
            4'hE, 4'hF, 4'hF, 4'hF
        };
        logic z;
        do_reset();
        for (int i = 0; i < 120; i++) begin
            z = (i < 47) || (i >= 95);
            cycle(i == 23 || i == 71, (i == 23) ? 16'h0070 : 16'h00A5, z, 1'b0);
            if (i >= 26 && (i - 26) % P == 0) begin
                vectors++;
                if (o_an !== exp_an[(i - 26) / P]) begin
                    errors++;
                    $display("FAIL lz_an cyc=%0d got %b exp %b", i, o_an, exp_an[(i - 26) / P]);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        int ticks = 0, tick_at = -1;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            cycle(i == 5 || i == 30, (i == 5) ? 16'h1234 : 16'h5678, 1'b0, i == 39);
            if (i == 39) begin
                vectors++;
                if (o_pend !== 1'b1 || o_an !== 4'hB) begin
                    errors++;
                    $display("FAIL mid_pre got pend=%b an=%b exp pend=1 an=1011", o_pend, o_an);
                end
            end
        end
        for (int j = 0; j < 30; j++) begin
            cycle(1'b0, 16'h0, 1'b0, 1'b0);
            if (j == 0) begin
                vectors++;
                if (o_pend !== 1'b0 || o_hex !== 4'h0) begin
                    errors++;
                    $display("FAIL mid_clear got pend=%b hex=%h exp pend=0 hex=0", o_pend, o_hex);
                end
            end
            vectors++;
            if (o_an !== scan_an[j]) begin
                errors++;
                $display("FAIL mid_scan cyc=%0d got %b exp %b", j, o_an, scan_an[j]);
            end
            if (o_tick === 1'b1) begin ticks++; tick_at = j; end
        end
        vectors++;
        if (ticks != 1 || tick_at != 23) begin
            errors++;
            $display("FAIL mid_tick got count=%0d at=%0d exp count=1 at=23", ticks, tick_at);
        end
    endtask

    initial begin
        reset = 1'b1; ld = 1'b0; bcd_in = '0; lz_en = 1'b0;
        test_reset();
        test_scan();
        test_load();
        test_back_to_back();
        test_boundary_ld();
        test_lz();
        test_mid_reset();
        vectors++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d left exp 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
